stall_buffer_stage: RTL and testbench

//  Upstream feeder for the pass-through component chain. Buffers the incoming value/enable

---
 rtl/stall_buffer_stage_if.sv | 28 ++
 rtl/stall_buffer_stage.sv | 118 +++++++++++
 tb/tb_stall_buffer_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/stall_buffer_stage_if.sv
// Stream bundle between the upstream feeder and the stall buffer.
// master: drives ctrl_stall/ctrl_clear/in_*, reads ctrl_stuck/out_*/level.
// slave : the buffer, reads ctrl_stall/ctrl_clear/in_*, drives ctrl_stuck/out_*/level.
interface stall_buffer_stage_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             ctrl_stall;
    logic             ctrl_clear;
    logic             ctrl_stuck;
    logic [WIDTH-1:0] in_value;
    logic             in_enable;
    logic [WIDTH-1:0] out_value;
    logic             out_enable;
    logic [LW-1:0]    level;

    modport master (
        output ctrl_stall, ctrl_clear, in_value, in_enable,
        input  ctrl_stuck, out_value, out_enable, level
    );

    modport slave (
        input  ctrl_stall, ctrl_clear, in_value, in_enable,
        output ctrl_stuck, out_value, out_enable, level
    );
endinterface

// File: rtl/stall_buffer_stage.sv
// Stall buffer: small FIFO feeding the pass-through chain, one word/cycle out
// while ctrl_stall is low. Ports: clock, reset (async, active-high), bus (slave).
module stall_buffer_stage #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int STUCK_LIMIT = 8
) (
    input logic                 clock,
    input logic                 reset,
    stall_buffer_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(STUCK_LIMIT + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [CW-1:0] LIMIT    = CW'(STUCK_LIMIT);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic             out_enable_q, out_enable_d;
    logic [CW-1:0]    stall_cnt_q, stall_cnt_d;
    logic             ovf_q, ovf_d;
    logic             push, pop;

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        out_value_d  = out_value_q;
        out_enable_d = 1'b0;
        stall_cnt_d  = stall_cnt_q;
        ovf_d        = ovf_q;
        pop          = 1'b0;
        push         = 1'b0;

        if (bus.ctrl_clear) begin
            state_d     = EMPTY;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            out_value_d = '0;
            stall_cnt_d = '0;
            ovf_d       = 1'b0;
        end else begin
            pop  = !bus.ctrl_stall && (state_q != EMPTY);
            // A full FIFO still accepts a word when the head leaves this cycle.
            push = bus.in_enable && ((state_q != FULL) || pop);

            if (bus.in_enable && !push)
                ovf_d = 1'b1;

            if (push) begin
                mem_d[wr_ptr_q] = bus.in_value;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end

            if (pop) begin
                out_value_d  = mem_q[rd_ptr_q];
                out_enable_d = 1'b1;
                rd_ptr_d     = rd_ptr_q + AW'(1);
            end

            level_d = level_q + LW'(push) - LW'(pop);

            if (level_d == '0)
                state_d = EMPTY;
            else if (level_d == FULL_LVL)
                state_d = FULL;
            else
                state_d = PARTIAL;

            if (!bus.ctrl_stall)
                stall_cnt_d = '0;
            else if (stall_cnt_q != LIMIT)
                stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            out_value_q  <= '0;
            out_enable_q <= 1'b0;
            stall_cnt_q  <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            out_value_q  <= out_value_d;
            out_enable_q <= out_enable_d;
            stall_cnt_q  <= stall_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.out_value  = out_value_q;
    assign bus.out_enable = out_enable_q;
    assign bus.level      = level_q;
    // Flag is decoded from registers only.
    assign bus.ctrl_stuck = ovf_q | (stall_cnt_q == LIMIT);
endmodule

// File: tb/tb_stall_buffer_stage.sv
// Directed bench for stall_buffer_stage: vector table plus
// hand sequences for async reset mid-stream and stall-limit flag.
module tb_stall_buffer_stage;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    stall_buffer_stage_if #(.WIDTH(16), .DEPTH(4)) bus ();

    stall_buffer_stage #(
        .WIDTH(16), .DEPTH(4), .STUCK_LIMIT(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        stall;
        logic        clear;
        logic        en;
        logic [15:0] val;
        logic        x_en;
        logic [15:0] x_val;
        logic [2:0]  x_lvl;
        logic        x_stuck;
    } vec_t;

    vec_t vecs [31];

    function automatic vec_t mk(logic s, logic c, logic e, logic [15:0] v,
                                logic xe, logic [15:0] xv, logic [2:0] xl,
                                logic xs);
        vec_t r;
        r.stall = s; r.clear = c; r.en = e; r.val = v;
        r.x_en = xe; r.x_val = xv; r.x_lvl = xl; r.x_stuck = xs;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic s, logic c, logic e, logic [15:0] v);
        bus.ctrl_stall = s;
        bus.ctrl_clear = c;
        bus.in_enable  = e;
        bus.in_value   = v;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(string tag, logic e, logic [15:0] v,
                           logic [2:0] l, logic s);
        chk({tag, " out_enable"}, 32'(bus.out_enable), 32'(e));
        chk({tag, " out_value"},  32'(bus.out_value),  32'(v));
        chk({tag, " level"},      32'(bus.level),      32'(l));
        chk({tag, " ctrl_stuck"}, 32'(bus.ctrl_stuck), 32'(s));
    endtask

    initial begin
        // in-order stream, no stall
        vecs[0]  = mk(0, 0, 1, 16'h0001, 0, 16'h0000, 1, 0);
        vecs[1]  = mk(0, 0, 1, 16'h0002, 1, 16'h0001, 1, 0);
        vecs[2]  = mk(0, 0, 1, 16'h0003, 1, 16'h0002, 1, 0);
        vecs[3]  = mk(0, 0, 0, 16'h0000, 1, 16'h0003, 0, 0);
        vecs[4]  = mk(0, 0, 0, 16'h0000, 0, 16'h0003, 0, 0);
        // fill under stall, then drain
        vecs[5]  = mk(1, 0, 1, 16'h00A0, 0, 16'h0003, 1, 0);
        vecs[6]  = mk(1, 0, 1, 16'h00A1, 0, 16'h0003, 2, 0);
        vecs[7]  = mk(1, 0, 1, 16'h00A2, 0, 16'h0003, 3, 0);
        vecs[8]  = mk(1, 0, 1, 16'h00A3, 0, 16'h0003, 4, 0);
        vecs[9]  = mk(0, 0, 0, 16'h0000, 1, 16'h00A0, 3, 0);
        vecs[10] = mk(0, 0, 0, 16'h0000, 1, 16'h00A1, 2, 0);
        vecs[11] = mk(0, 0, 0, 16'h0000, 1, 16'h00A2, 1, 0);
        vecs[12] = mk(0, 0, 0, 16'h0000, 1, 16'h00A3, 0, 0);
        vecs[13] = mk(0, 0, 0, 16'h0000, 0, 16'h00A3, 0, 0);
        // overflow while stalled, then clear
        vecs[14] = mk(1, 0, 1, 16'h00B0, 0, 16'h00A3, 1, 0);
        vecs[15] = mk(1, 0, 1, 16'h00B1, 0, 16'h00A3, 2, 0);
        vecs[16] = mk(1, 0, 1, 16'h00B2, 0, 16'h00A3, 3, 0);
        vecs[17] = mk(1, 0, 1, 16'h00B3, 0, 16'h00A3, 4, 0);
        vecs[18] = mk(1, 0, 1, 16'h00FF, 0, 16'h00A3, 4, 1);
        vecs[19] = mk(1, 1, 1, 16'h1234, 0, 16'h0000, 0, 0);
        vecs[20] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        // push into full FIFO while popping: no overflow
        vecs[21] = mk(1, 0, 1, 16'h00C0, 0, 16'h0000, 1, 0);
        vecs[22] = mk(1, 0, 1, 16'h00C1, 0, 16'h0000, 2, 0);
        vecs[23] = mk(1, 0, 1, 16'h00C2, 0, 16'h0000, 3, 0);
        vecs[24] = mk(1, 0, 1, 16'h00C3, 0, 16'h0000, 4, 0);
        vecs[25] = mk(0, 0, 1, 16'h0BEE, 1, 16'h00C0, 4, 0);
        vecs[26] = mk(0, 0, 0, 16'h0000, 1, 16'h00C1, 3, 0);
        vecs[27] = mk(0, 0, 0, 16'h0000, 1, 16'h00C2, 2, 0);
        vecs[28] = mk(0, 0, 0, 16'h0000, 1, 16'h00C3, 1, 0);
        vecs[29] = mk(0, 0, 0, 16'h0000, 1, 16'h0BEE, 0, 0);
        vecs[30] = mk(0, 0, 0, 16'h0000, 0, 16'h0BEE, 0, 0);

        drive(0, 0, 0, 16'h0000);
        reset = 1'b1;
        step();
        step();
        chk_all("reset", 0, 16'h0000, 0, 0);
        reset = 1'b0;
        step();
        chk_all("idle", 0, 16'h0000, 0, 0);

        for (int i = 0; i < 31; i++) begin
            drive(vecs[i].stall, vecs[i].clear, vecs[i].en, vecs[i].val);
            step();
            chk_all($sformatf("r%0d", i), vecs[i].x_en, vecs[i].x_val,
                    vecs[i].x_lvl, vecs[i].x_stuck);
        end

        // async reset mid-stream with level 3
        drive(0, 0, 1, 16'h00D1);
        step();
        drive(0, 0, 1, 16'h00D2);
        step();
        drive(1, 0, 1, 16'h00D3);
        step();
        drive(1, 0, 1, 16'h00D4);
        step();
        chk_all("pre_rst", 0, 16'h00D1, 3, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 16'h0000, 0, 0);
        step();
        chk_all("held_rst", 0, 16'h0000, 0, 0);
        drive(0, 0, 0, 16'h0000);
        reset = 1'b0;
        step();
        chk_all("post_rst", 0, 16'h0000, 0, 0);

        // stall limit: flag after 8th stalled edge, saturates, drops on release
        for (int i = 1; i <= 9; i++) begin
            drive(1, 0, 0, 16'h0000);
            step();
            chk($sformatf("stall%0d ctrl_stuck", i),
                32'(bus.ctrl_stuck), (i >= 8) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 0, 16'h0000);
        step();
        chk("unstall ctrl_stuck", 32'(bus.ctrl_stuck), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
